// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE    = 2'd0,
    SLOT_PENDING = 2'd1,
    SLOT_FILLED  = 2'd2
  } slot_state_e;

  localparam logic [31:0] BASEADDR_DEFAULT = 32'h0100_0000;
  localparam int unsigned PC_INC           = 4;
  localparam logic [31:0] NOP_INSN         = 32'h0000_0013;

endpackage

// File: rtl/fetch_slot_queue.sv
// In-order slot ring: tail allocates at request accept, pend fills on response,
// head pops to decode. Flush frees every slot and rewinds all pointers.
//   state        | meaning
//   SLOT_FREE    | slot unused, may be allocated by tail
//   SLOT_PENDING | request accepted, waiting for memory response
//   SLOT_FILLED  | instruction returned, waiting for decode
module fetch_slot_queue
  import fetch_pkg::*;
#(
  parameter int AWIDTH = 32,
  parameter int DWIDTH = 32,
  parameter int DEPTH  = 2,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc,
  input  logic [AWIDTH-1:0] alloc_pc,
  input  logic              fill,
  input  logic [DWIDTH-1:0] fill_data,
  input  logic              pop,
  output logic              tail_free,
  output logic              pend_valid,
  output logic [CW-1:0]     pend_count,
  output logic              head_filled,
  output logic [DWIDTH-1:0] head_insn,
  output logic [AWIDTH-1:0] head_pc
);

  slot_state_e       state  [DEPTH];
  logic [AWIDTH-1:0] pc_q   [DEPTH];
  logic [DWIDTH-1:0] insn_q [DEPTH];
  logic [PW-1:0]     head, pend, tail;

  // alloc/fill/pop target slots in distinct states, so they never collide
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head <= '0;
      pend <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        state[i]  <= SLOT_FREE;
        pc_q[i]   <= '0;
        insn_q[i] <= '0;
      end
    end else if (flush) begin
      head <= '0;
      pend <= '0;
      tail <= '0;
      for (int i = 0; i < DEPTH; i++) state[i] <= SLOT_FREE;
    end else begin
      if (pop) begin
        state[head] <= SLOT_FREE;
        head        <= head + PW'(1);
      end
      if (fill) begin
        state[pend]  <= SLOT_FILLED;
        insn_q[pend] <= fill_data;
        pend         <= pend + PW'(1);
      end
      if (alloc) begin
        state[tail] <= SLOT_PENDING;
        pc_q[tail]  <= alloc_pc;
        tail        <= tail + PW'(1);
      end
    end
  end

  always_comb begin
    pend_count = '0;
    for (int i = 0; i < DEPTH; i++)
      if (state[i] == SLOT_PENDING) pend_count = pend_count + CW'(1);
  end

  assign tail_free   = (state[tail] == SLOT_FREE);
  assign pend_valid  = (state[pend] == SLOT_PENDING);
  assign head_filled = (state[head] == SLOT_FILLED);
  assign head_insn   = insn_q[head];
  assign head_pc     = pc_q[head];

endmodule

// File: rtl/fetch_queue.sv
// Fetch front end: issues in-order imem requests, buffers returned words and
// hands them to decode; a redirect flushes the queue and drops stale responses.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int                AWIDTH   = 32,
  parameter int                DWIDTH   = 32,
  parameter int                DEPTH    = 2,
  parameter logic [AWIDTH-1:0] BASEADDR = AWIDTH'(BASEADDR_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req_valid_o,
  input  logic              imem_req_ready_i,
  output logic [AWIDTH-1:0] imem_req_addr_o,
  input  logic              imem_rsp_valid_i,
  input  logic [DWIDTH-1:0] imem_rsp_data_i,
  input  logic              redirect_i,
  input  logic [AWIDTH-1:0] redirect_pc_i,
  output logic              insn_valid_o,
  input  logic              insn_ready_i,
  output logic [DWIDTH-1:0] insn_o,
  output logic [AWIDTH-1:0] pc_o
);

  localparam int CW  = $clog2(DEPTH + 1);
  localparam int DCW = $clog2(2 * DEPTH + 1);

  logic [AWIDTH-1:0] fetch_pc;
  logic [DCW-1:0]    drop_cnt, drop_nxt;
  logic              tail_free, pend_valid, head_filled;
  logic [CW-1:0]     pend_count;
  logic [DWIDTH-1:0] head_insn;
  logic [AWIDTH-1:0] head_pc;
  logic              req_fire, fill, pop;

  assign imem_req_valid_o = reset && tail_free && !redirect_i;
  assign imem_req_addr_o  = fetch_pc;
  assign req_fire         = imem_req_valid_o && imem_req_ready_i;
  assign pop              = head_filled && insn_ready_i;

  // a response always retires either one owed drop or the oldest pending slot
  always_comb begin
    drop_nxt = drop_cnt;
    fill     = 1'b0;
    if (redirect_i) begin
      drop_nxt = drop_cnt + DCW'(pend_count);
      if (imem_rsp_valid_i && drop_nxt != '0) drop_nxt = drop_nxt - DCW'(1);
    end else if (imem_rsp_valid_i) begin
      if (drop_cnt != '0) drop_nxt = drop_cnt - DCW'(1);
      else                fill     = pend_valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= BASEADDR;
      drop_cnt <= '0;
    end else begin
      drop_cnt <= drop_nxt;
      if (redirect_i)    fetch_pc <= {redirect_pc_i[AWIDTH-1:2], 2'b00};
      else if (req_fire) fetch_pc <= fetch_pc + AWIDTH'(PC_INC);
    end
  end

  fetch_slot_queue #(
    .AWIDTH(AWIDTH),
    .DWIDTH(DWIDTH),
    .DEPTH (DEPTH)
  ) u_slots (
    .clk        (clk),
    .reset      (reset),
    .flush      (redirect_i),
    .alloc      (req_fire),
    .alloc_pc   (fetch_pc),
    .fill       (fill),
    .fill_data  (imem_rsp_data_i),
    .pop        (pop),
    .tail_free  (tail_free),
    .pend_valid (pend_valid),
    .pend_count (pend_count),
    .head_filled(head_filled),
    .head_insn  (head_insn),
    .head_pc    (head_pc)
  );

  assign insn_valid_o = head_filled;
  assign insn_o       = head_filled ? head_insn : '0;
  assign pc_o         = head_filled ? head_pc : '0;

  rsp_has_owner: assert property (@(posedge clk) disable iff (!reset)
    !(imem_rsp_valid_i && drop_cnt == '0 && pend_count == '0))
    else $error("fetch_queue: imem response with nothing outstanding");

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue (DEPTH=2): hand-computed request/insn sequences.
module tb_fetch_queue;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid, req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        insn_valid, insn_ready;
  logic [31:0] insn, pc;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_queue dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid_o(req_valid),
    .imem_req_ready_i(req_ready),
    .imem_req_addr_o (req_addr),
    .imem_rsp_valid_i(rsp_valid),
    .imem_rsp_data_i (rsp_data),
    .redirect_i      (redirect),
    .redirect_pc_i   (redirect_pc),
    .insn_valid_o    (insn_valid),
    .insn_ready_i    (insn_ready),
    .insn_o          (insn),
    .pc_o            (pc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [31:0] a);
    chk({tag, ".req_valid"}, 32'(req_valid), 32'(v));
    if (v) chk({tag, ".req_addr"}, req_addr, a);
  endtask

  task automatic chk_insn(input string tag, input logic v, input logic [31:0] i, input logic [31:0] p);
    chk({tag, ".insn_valid"}, 32'(insn_valid), 32'(v));
    chk({tag, ".insn"}, insn, i);
    chk({tag, ".pc"}, pc, p);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    req_ready = 1'b0; rsp_valid = 1'b0; rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; insn_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
  endtask

  initial begin
    req_ready = 1'b1; rsp_valid = 1'b0; rsp_data = '0;
    redirect = 1'b0; redirect_pc = '0; insn_ready = 1'b1;
    #1 reset = 1'b0;
    settle();
    chk_req("rst", 1'b0, 32'h0);
    chk_insn("rst", 1'b0, 32'h0, 32'h0);
    tick(); tick();
    reset = 1'b1;

    // t1: 1-cycle latency, decode always ready
    req_ready = 1'b1; insn_ready = 1'b1; settle();
    chk_req("t1c0", 1'b1, 32'h0100_0000);
    chk_insn("t1c0", 1'b0, 32'h0, 32'h0);
    tick(); rsp_valid = 1'b1; rsp_data = 32'hA000_0000; settle();
    chk_req("t1c1", 1'b1, 32'h0100_0004);
    tick(); rsp_data = 32'hA000_0001; settle();
    chk_insn("t1c2", 1'b1, 32'hA000_0000, 32'h0100_0000);
    chk_req("t1c2", 1'b0, 32'h0);
    tick(); rsp_valid = 1'b0; settle();
    chk_insn("t1c3", 1'b1, 32'hA000_0001, 32'h0100_0004);
    chk_req("t1c3", 1'b1, 32'h0100_0008);
    tick(); rsp_valid = 1'b1; rsp_data = 32'hA000_0002; settle();
    chk_insn("t1c4", 1'b0, 32'h0, 32'h0);
    chk_req("t1c4", 1'b1, 32'h0100_000C);
    req_ready = 1'b0;
    tick(); rsp_valid = 1'b0; settle();
    chk_insn("t1c5", 1'b1, 32'hA000_0002, 32'h0100_0008);
    tick();

    // t2: decode stalled, queue fills after two requests
    do_reset(); req_ready = 1'b1; insn_ready = 1'b0; settle();
    chk_req("t2c0", 1'b1, 32'h0100_0000);
    tick(); rsp_valid = 1'b1; rsp_data = 32'hB000_0000; settle();
    chk_req("t2c1", 1'b1, 32'h0100_0004);
    tick(); rsp_data = 32'hB000_0001; settle();
    chk_req("t2c2", 1'b0, 32'h0);
    chk_insn("t2c2", 1'b1, 32'hB000_0000, 32'h0100_0000);
    tick(); rsp_valid = 1'b0; settle();
    chk_req("t2c3", 1'b0, 32'h0);
    insn_ready = 1'b1; settle();
    chk_req("t2c3pop", 1'b0, 32'h0);
    tick(); insn_ready = 1'b0; settle();
    chk_req("t2c4", 1'b1, 32'h0100_0008);
    chk_insn("t2c4", 1'b1, 32'hB000_0001, 32'h0100_0004);

    // t3: redirect with two requests outstanding, misaligned target
    do_reset(); req_ready = 1'b1; insn_ready = 1'b0;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0100_0103; settle();
    chk_req("t3redir", 1'b0, 32'h0);
    tick(); redirect = 1'b0; rsp_valid = 1'b1; rsp_data = 32'hDEAD_0000; settle();
    chk_req("t3c3", 1'b1, 32'h0100_0100);
    tick(); rsp_data = 32'hDEAD_0004; settle();
    chk_insn("t3c4", 1'b0, 32'h0, 32'h0);
    chk_req("t3c4", 1'b1, 32'h0100_0104);
    tick(); rsp_data = 32'hC000_0100; settle();
    chk_insn("t3c5", 1'b0, 32'h0, 32'h0);
    chk_req("t3c5", 1'b0, 32'h0);
    tick(); rsp_valid = 1'b0; settle();
    chk_insn("t3c6", 1'b1, 32'hC000_0100, 32'h0100_0100);

    // t4a: redirect coinciding with a stale response, two pending
    do_reset(); req_ready = 1'b1; insn_ready = 1'b1;
    tick(); tick();
    redirect = 1'b1; redirect_pc = 32'h0100_0200;
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_1000; settle();
    chk_req("t4redir", 1'b0, 32'h0);
    tick(); redirect = 1'b0; rsp_data = 32'hDEAD_1004; settle();
    chk_insn("t4c3", 1'b0, 32'h0, 32'h0);
    chk_req("t4c3", 1'b1, 32'h0100_0200);
    tick(); rsp_data = NOP_INSN; settle();
    chk_insn("t4c4", 1'b0, 32'h0, 32'h0);
    chk_req("t4c4", 1'b1, 32'h0100_0204);
    tick(); rsp_valid = 1'b0; req_ready = 1'b0; settle();
    chk_insn("t4c5", 1'b1, NOP_INSN, 32'h0100_0200);
    // t4b: redirect + pop + stale response for the only pending slot
    redirect = 1'b1; redirect_pc = 32'h0100_0300;
    rsp_valid = 1'b1; rsp_data = 32'hDEAD_1204; settle();
    chk_req("t4bredir", 1'b0, 32'h0);
    tick(); redirect = 1'b0; rsp_valid = 1'b0; req_ready = 1'b1; settle();
    chk_insn("t4bc7", 1'b0, 32'h0, 32'h0);
    chk_req("t4bc7", 1'b1, 32'h0100_0300);
    tick(); rsp_valid = 1'b1; rsp_data = 32'hE000_0300; settle();
    chk_req("t4bc8", 1'b1, 32'h0100_0304);
    tick(); rsp_valid = 1'b0; req_ready = 1'b0; settle();
    chk_insn("t4bc9", 1'b1, 32'hE000_0300, 32'h0100_0300);

    // t5: request back-pressure 1,0,0,1 with 3-cycle memory latency
    do_reset(); insn_ready = 1'b1; req_ready = 1'b1; settle();
    chk_req("t5c0", 1'b1, 32'h0100_0000);
    tick(); req_ready = 1'b0; settle();
    chk_req("t5c1", 1'b1, 32'h0100_0004);
    tick(); settle();
    chk_req("t5c2", 1'b1, 32'h0100_0004);
    tick(); req_ready = 1'b1; rsp_valid = 1'b1; rsp_data = 32'hF000_0000; settle();
    chk_req("t5c3", 1'b1, 32'h0100_0004);
    tick(); req_ready = 1'b0; rsp_valid = 1'b0; settle();
    chk_insn("t5c4", 1'b1, 32'hF000_0000, 32'h0100_0000);
    chk_req("t5c4", 1'b0, 32'h0);
    tick(); settle();
    chk_req("t5c5", 1'b1, 32'h0100_0008);
    tick(); rsp_valid = 1'b1; rsp_data = 32'hF000_0004;
    tick(); rsp_valid = 1'b0; settle();
    chk_insn("t5c7", 1'b1, 32'hF000_0004, 32'h0100_0004);

    // t6: asynchronous reset with one slot filled and one pending
    do_reset(); req_ready = 1'b1; insn_ready = 1'b0;
    tick(); rsp_valid = 1'b1; rsp_data = 32'h1234_5678;
    tick(); rsp_valid = 1'b0; settle();
    chk_insn("t6pre", 1'b1, 32'h1234_5678, 32'h0100_0000);
    #2 reset = 1'b0;
    #1;
    chk_insn("t6rst", 1'b0, 32'h0, 32'h0);
    chk_req("t6rst", 1'b0, 32'h0);
    tick(); tick();
    reset = 1'b1; settle();
    chk_req("t6rel", 1'b1, 32'h0100_0000);
    chk_insn("t6rel", 1'b0, 32'h0, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
